// File: rtl/rs_syndrome_calc.sv
// RS(255,k) syndrome calculator over GF(256), field polynomial 0x11D, alpha = 0x02.
// Bytes arrive highest-degree coefficient first. Each byte folds into every
// syndrome by Horner's rule: S_j = S_j * alpha^(FCR+j) + r_i.
// The finished syndrome set is held until the Berlekamp-Massey stage accepts it.
//
//   state | meaning
//   IDLE  | waiting for the first byte of a codeword; that byte seeds every S_j
//   ACC   | folding the remaining bytes into the syndromes
//   HOLD  | syndrome set presented on out_*, waiting for out_ready
module rs_syndrome_calc #(
  parameter int NSYM  = 16,
  parameter int FCR   = 0,
  parameter int N_MAX = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [8*NSYM-1:0] out_syndromes,
  output logic [7:0]        out_len,
  output logic              out_zero,
  output logic              out_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [8:0] CNT_MAX = 9'h1FF;
  localparam logic [8:0] N_MAX_C = 9'(N_MAX);
  localparam logic [8:0] NSYM_C  = 9'(NSYM);

  // GF(256) multiply, shift-and-add with 0x11D reduction.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1D) : {x[6:0], 1'b0};
    end
    return p;
  endfunction

  // alpha^e, evaluated at elaboration only.
  function automatic logic [7:0] alpha_pow(input int e);
    logic [7:0] v;
    v = 8'h01;
    for (int i = 0; i < e; i++) v = gf_mul(v, 8'h02);
    return v;
  endfunction

  state_t              state_q;
  state_t              state_d;
  logic [8*NSYM-1:0]   s_q;
  logic [8*NSYM-1:0]   s_next;
  logic [8:0]          cnt_q;
  logic [8:0]          cnt_next;
  logic                zero_q;
  logic                err_q;
  logic                accept;

  assign accept = in_valid & in_ready;

  // In IDLE the old syndromes are dropped, so the first byte seeds every S_j directly.
  for (genvar j = 0; j < NSYM; j++) begin : g_syn
    localparam logic [7:0] ALPHA_J = alpha_pow((FCR + j) % 255);
    assign s_next[8*j +: 8] = ((state_q == IDLE) ? 8'h00 : gf_mul(s_q[8*j +: 8], ALPHA_J)) ^ in_data;
  end

  assign cnt_next = (state_q == IDLE) ? 9'd1 :
                    (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 9'd1;

  assign out_syndromes = s_q;
  assign out_len       = 8'(NSYM);
  assign out_zero      = zero_q;
  assign out_err       = err_q;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b1;
    out_valid = 1'b0;
    case (state_q)
      IDLE: if (accept) state_d = in_last ? HOLD : ACC;
      ACC:  if (accept && in_last) state_d = HOLD;
      HOLD: begin
        in_ready  = 1'b0;
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Syndrome accumulators, byte count, and the flags latched at end of frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_q    <= '0;
      cnt_q  <= '0;
      zero_q <= 1'b0;
      err_q  <= 1'b0;
    end else if (accept) begin
      s_q   <= s_next;
      cnt_q <= cnt_next;
      if (in_last) begin
        zero_q <= ~|s_next;
        err_q  <= (cnt_next > N_MAX_C) || (cnt_next <= NSYM_C);
      end
    end else if (out_valid && out_ready) begin
      cnt_q  <= '0;
      zero_q <= 1'b0;
      err_q  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rs_syndrome_calc.sv
// Bench for rs_syndrome_calc: table of frames, expected syndromes computed by
// direct polynomial evaluation with log/antilog tables, scoreboard popped on handshake.
module tb_rs_syndrome_calc;

  localparam int NSYM = 16;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid;
  logic [7:0]         in_data;
  logic               in_last;
  logic               in_ready;
  logic               out_valid;
  logic               out_ready;
  logic [8*NSYM-1:0]  out_syndromes;
  logic [7:0]         out_len;
  logic               out_zero;
  logic               out_err;

  rs_syndrome_calc #(.NSYM(NSYM), .FCR(0), .N_MAX(255)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_syndromes(out_syndromes),
    .out_len(out_len), .out_zero(out_zero), .out_err(out_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           len;
    int           kind;       // 0 zeros, 1 zeros+01 last, 2 zeros+01+00 last, 3 random
    bit           gap;        // idle cycle after every byte
    int           hold;       // cycles out_ready stays low after out_valid
    bit           use_const;
    logic [127:0] exp_const;
    int           exp_zero;   // -1: derive from model
    bit           exp_err;
  } vec_t;

  typedef struct {
    logic [127:0] syn;
    logic         zero;
    logic         err;
  } exp_t;

  localparam logic [127:0] ALPHA_SYN = 128'h261387CDE8743A1D8040201008040201;

  vec_t        vecs[10];
  exp_t        sb[$];
  exp_t        e_pop;
  logic [7:0]  frame[$];
  int          gexp[512];
  int          glog[256];
  int          n_pass = 0;
  int          n_total = 0;
  logic        pend = 1'b0;
  logic [127:0] held_syn;
  logic [1:0]  held_flags;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic int gmul(input int a, input int b);
    if (a == 0 || b == 0) return 0;
    return gexp[glog[a] + glog[b]];
  endfunction

  // S_j = sum_i r_i * alpha^(j*(n-1-i)), evaluated term by term.
  function automatic logic [127:0] ref_syn();
    logic [127:0] s;
    int n;
    s = '0;
    n = frame.size();
    for (int j = 0; j < NSYM; j++) begin
      int acc;
      acc = 0;
      for (int i = 0; i < n; i++)
        acc = acc ^ gmul(int'(frame[i]), gexp[(j * (n - 1 - i)) % 255]);
      s[8*j +: 8] = 8'(acc);
    end
    return s;
  endfunction

  // Scoreboard consumer and HOLD stability monitor.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (pend) begin
        check("hold_syn_stable", out_syndromes, held_syn);
        check("hold_flags_stable", {126'd0, out_zero, out_err}, {126'd0, held_flags});
        check("hold_in_ready", {127'd0, in_ready}, 128'd0);
      end
      if (out_ready) begin
        if (sb.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_out: out_valid with syndromes %h, none expected", out_syndromes);
        end else begin
          e_pop = sb.pop_front();
          check("syndromes", out_syndromes, e_pop.syn);
          check("out_zero", {127'd0, out_zero}, {127'd0, e_pop.zero});
          check("out_err", {127'd0, out_err}, {127'd0, e_pop.err});
          check("out_len", {120'd0, out_len}, 128'd16);
        end
        pend = 1'b0;
      end else begin
        pend       = 1'b1;
        held_syn   = out_syndromes;
        held_flags = {out_zero, out_err};
      end
    end else begin
      pend = 1'b0;
    end
  end

  task automatic build_frame(input vec_t v);
    frame.delete();
    for (int i = 0; i < v.len; i++) begin
      logic [7:0] b;
      case (v.kind)
        0: b = 8'h00;
        1: b = (i == v.len - 1) ? 8'h01 : 8'h00;
        2: b = (i == v.len - 2) ? 8'h01 : 8'h00;
        default: b = 8'($urandom_range(0, 255));
      endcase
      frame.push_back(b);
    end
  endtask

  task automatic send_frame(input vec_t v);
    exp_t e;
    logic [127:0] m;
    build_frame(v);
    m = ref_syn();
    e.syn  = v.use_const ? v.exp_const : m;
    e.zero = (v.exp_zero < 0) ? (m == '0) : v.exp_zero[0];
    e.err  = v.exp_err;
    sb.push_back(e);
    out_ready = (v.hold > 0) ? 1'b0 : 1'b1;
    for (int i = 0; i < v.len; i++) begin
      in_valid = 1'b1;
      in_data  = frame[i];
      in_last  = (i == v.len - 1);
      @(posedge clk); #1;
      if (v.gap && i != v.len - 1) begin
        in_valid = 1'b0;
        in_data  = 8'hA5;
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("latency_out_valid", {127'd0, out_valid}, 128'd1);
    check("hold_ready_low", {127'd0, in_ready}, 128'd0);
    for (int k = 0; k < v.hold; k++) begin
      in_valid = 1'b1;
      in_last  = 1'b1;
      in_data  = 8'($urandom_range(1, 255));
      @(posedge clk); #1;
      check("hold_valid_high", {127'd0, out_valid}, 128'd1);
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("idle_resumed", {126'd0, out_valid, in_ready}, 128'd1);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_valid_ready"}, {126'd0, out_valid, in_ready}, 128'd1);
    check({tag, "_syn"}, out_syndromes, 128'd0);
    check({tag, "_flags"}, {126'd0, out_zero, out_err}, 128'd0);
  endtask

  initial begin
    int x;
    x = 1;
    for (int i = 0; i < 255; i++) begin
      gexp[i] = x;
      gexp[i + 255] = x;
      glog[x] = i;
      x = x << 1;
      if (x > 255) x = x ^ 'h11D;
    end
    gexp[510] = gexp[0];
    gexp[511] = gexp[1];
    glog[0] = 0;

    vecs[0] = '{255, 0, 1'b0, 0, 1'b0, '0, 1, 1'b0};
    vecs[1] = '{255, 1, 1'b0, 0, 1'b0, '0, 0, 1'b0};
    vecs[2] = '{255, 2, 1'b0, 0, 1'b1, ALPHA_SYN, 0, 1'b0};
    vecs[3] = '{255, 2, 1'b1, 5, 1'b1, ALPHA_SYN, 0, 1'b0};
    vecs[4] = '{10,  3, 1'b0, 0, 1'b0, '0, -1, 1'b1};
    vecs[5] = '{256, 0, 1'b0, 0, 1'b0, '0, 1, 1'b1};
    vecs[6] = '{1,   3, 1'b0, 1, 1'b0, '0, -1, 1'b1};
    vecs[7] = '{16,  3, 1'b0, 0, 1'b0, '0, -1, 1'b1};
    vecs[8] = '{17,  3, 1'b0, 0, 1'b0, '0, -1, 1'b0};
    vecs[9] = '{40,  3, 1'b1, 2, 1'b0, '0, -1, 1'b0};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_last   = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("reset");
    check("reset_len", {120'd0, out_len}, 128'd16);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int v = 0; v < 10; v++) begin
      send_frame(vecs[v]);
      @(posedge clk); #1;
    end

    // Abort a frame with reset after 100 bytes, then send a clean all-zero frame.
    for (int i = 0; i < 100; i++) begin
      in_valid = 1'b1;
      in_data  = 8'($urandom_range(1, 255));
      in_last  = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst_n    = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_reset_state("midframe_reset");
    repeat (3) @(posedge clk);
    #1;
    check("no_out_after_abort", {127'd0, out_valid}, 128'd0);
    send_frame(vecs[0]);

    // Reset while holding a result discards it.
    vecs[0].hold = 3;
    build_frame(vecs[1]);
    for (int i = 0; i < 255; i++) begin
      in_valid = 1'b1;
      in_data  = frame[i];
      in_last  = (i == 254);
      out_ready = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("hold_before_reset", {127'd0, out_valid}, 128'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_reset_state("hold_reset");
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    check("sb_drained", 128'(sb.size()), 128'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
